// File: rtl/inst_encoder.sv
// Streaming RV32I encoder: turns abstract R/I/LUI/LI operations into packed
// instruction words, expanding LI into a LUI+ADDI pair when it needs two words.
module inst_encoder #(
  parameter bit COMPACT_LI = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_kind,
  input  logic [3:0]  in_alu_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_last,
  output logic        err_illegal
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_PEND2 = 1'b1} state_t;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_out_valid;
  logic [31:0] r_out_inst;
  logic        r_out_last;
  logic        r_err;
  logic [31:0] r_pend_inst;

  logic [2:0]  w_f3;
  logic        w_op3;
  logic        w_fits12;
  logic [11:0] w_lo;
  logic [19:0] w_hi;
  logic        w_legal;
  logic        w_two;
  logic        w_first_last;
  logic [31:0] w_first;
  logic [31:0] w_second;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_load_first;
  logic        w_load_second;

  assign w_f3     = in_alu_opcode[2:0];
  assign w_op3    = in_alu_opcode[3];
  assign w_fits12 = (in_imm[31:11] == {21{in_imm[11]}});
  assign w_lo     = in_imm[11:0];
  // ADDI sign-extends lo, so the upper part absorbs a borrow when lo[11] is set.
  assign w_hi     = in_imm[31:12] + {19'd0, in_imm[11]};

  // Decode the offered operation into its first word, optional second word and legality.
  always_comb begin
    w_legal      = 1'b0;
    w_two        = 1'b0;
    w_first_last = 1'b1;
    w_first      = 32'd0;
    w_second     = 32'd0;
    case (in_kind)
      3'd0: begin
        w_legal = !w_op3 || (w_f3 == 3'b000) || (w_f3 == 3'b101);
        w_first = {1'b0, w_op3, 5'b00000, in_rs2, in_rs1, w_f3, in_rd, OPC_R};
      end
      3'd1: begin
        if ((w_f3 == 3'b001) || (w_f3 == 3'b101)) begin
          w_legal = (in_imm[31:5] == 27'd0) && !((w_f3 == 3'b001) && w_op3);
          w_first = {1'b0, w_op3, 5'b00000, in_imm[4:0], in_rs1, w_f3, in_rd, OPC_I};
        end else begin
          w_legal = !w_op3 && w_fits12;
          w_first = {in_imm[11:0], in_rs1, w_f3, in_rd, OPC_I};
        end
      end
      3'd2: begin
        w_legal = 1'b1;
        w_first = {in_imm[31:12], in_rd, OPC_LUI};
      end
      3'd3: begin
        w_legal = 1'b1;
        if (COMPACT_LI && w_fits12) begin
          w_first = {w_lo, 5'd0, 3'b000, in_rd, OPC_I};
        end else if (COMPACT_LI && (w_lo == 12'd0)) begin
          w_first = {w_hi, in_rd, OPC_LUI};
        end else begin
          w_first      = {w_hi, in_rd, OPC_LUI};
          w_first_last = 1'b0;
          w_two        = 1'b1;
          w_second     = {w_lo, in_rd, 3'b000, in_rd, OPC_I};
        end
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_load_first && w_two) w_state_nxt = S_PEND2;
        else                       w_state_nxt = S_IDLE;
      end
      S_PEND2: begin
        if (w_load_second) w_state_nxt = S_IDLE;
        else               w_state_nxt = S_PEND2;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: handshake and output-register load strobes.
  always_comb begin
    w_in_ready    = 1'b0;
    w_load_second = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready    = !r_out_valid || out_ready;
        w_load_second = 1'b0;
      end
      S_PEND2: begin
        w_in_ready    = 1'b0;
        w_load_second = out_ready;
      end
      default: begin
        w_in_ready    = 1'b0;
        w_load_second = 1'b0;
      end
    endcase
    w_accept     = in_valid && w_in_ready;
    w_load_first = w_accept && w_legal;
  end

  // Output word register, pending ADDI and illegal-drop pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_inst  <= 32'd0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
      r_pend_inst <= 32'd0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (w_load_first) begin
        r_out_valid <= 1'b1;
        r_out_inst  <= w_first;
        r_out_last  <= w_first_last;
        r_pend_inst <= w_two ? w_second : r_pend_inst;
      end else if (w_load_second) begin
        r_out_valid <= 1'b1;
        r_out_inst  <= r_pend_inst;
        r_out_last  <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_inst    = r_out_inst;
  assign out_last    = r_out_last;
  assign err_illegal = r_err;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder (compact and non-compact LI builds).
module tb_inst_encoder;

  logic        clk;
  logic        reset_n;
  logic        in_valid0, in_valid1;
  logic [2:0]  in_kind;
  logic [3:0]  in_alu_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_ready;
  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [31:0] out_inst0, out_inst1;
  logic        out_last0, out_last1;
  logic        err0, err1;

  int n_checks = 0;
  int n_fail   = 0;

  inst_encoder #(.COMPACT_LI(1'b1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_kind(in_kind), .in_alu_opcode(in_alu_opcode), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid0), .out_ready(out_ready), .out_inst(out_inst0),
    .out_last(out_last0), .err_illegal(err0)
  );

  inst_encoder #(.COMPACT_LI(1'b0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_kind(in_kind), .in_alu_opcode(in_alu_opcode), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid1), .out_ready(out_ready), .out_inst(out_inst1),
    .out_last(out_last1), .err_illegal(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for a single cycle to dut0 (to1=0) or dut1 (to1=1).
  task automatic drive(input logic [2:0] k, input logic [3:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                       input bit to1);
    in_kind       = k;
    in_alu_opcode = op;
    in_rd         = rd;
    in_rs1        = rs1;
    in_rs2        = rs2;
    in_imm        = imm;
    if (to1) in_valid1 = 1'b1;
    else     in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_w;
    reset_n = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0; out_ready = 1'b1;
    in_kind = 3'd0; in_alu_opcode = 4'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_imm = 32'd0;
    repeat (2) tick();
    chk("rst_valid", {31'd0, out_valid0}, 32'd0);
    chk("rst_inst", out_inst0, 32'd0);
    chk("rst_last", {31'd0, out_last0}, 32'd0);
    chk("rst_err", {31'd0, err0}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_ready", {31'd0, in_ready0}, 32'd1);

    // SUB x3,x1,x2
    drive(3'd0, 4'h8, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    chk("sub_valid", {31'd0, out_valid0}, 32'd1);
    chk("sub_inst", out_inst0, 32'h402081B3);
    chk("sub_last", {31'd0, out_last0}, 32'd1);
    tick();
    chk("sub_drain", {31'd0, out_valid0}, 32'd0);

    // ADDI x5,x0,-1
    drive(3'd1, 4'h0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
    chk("addi_inst", out_inst0, 32'hFFF00293);
    chk("addi_err", {31'd0, err0}, 32'd0);

    // SRAI x2,x2,3
    drive(3'd1, 4'hD, 5'd2, 5'd2, 5'd0, 32'd3, 1'b0);
    chk("srai_inst", out_inst0, 32'h40315113);
    chk("srai_valid", {31'd0, out_valid0}, 32'd1);

    // SRAI with shamt 33 is illegal
    drive(3'd1, 4'hD, 5'd2, 5'd2, 5'd0, 32'd33, 1'b0);
    chk("srai33_valid", {31'd0, out_valid0}, 32'd0);
    chk("srai33_err", {31'd0, err0}, 32'd1);
    tick();
    chk("srai33_err_pulse", {31'd0, err0}, 32'd0);

    // LI x10,0x12345FFF with a stalled consumer
    out_ready = 1'b0;
    drive(3'd3, 4'h0, 5'd10, 5'd0, 5'd0, 32'h12345FFF, 1'b0);
    chk("li_lui_inst", out_inst0, 32'h12346537);
    chk("li_lui_last", {31'd0, out_last0}, 32'd0);
    chk("li_ready_0", {31'd0, in_ready0}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("li_hold_inst", out_inst0, 32'h12346537);
      chk("li_hold_last", {31'd0, out_last0}, 32'd0);
      chk("li_hold_ready", {31'd0, in_ready0}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("li_pend_ready", {31'd0, in_ready0}, 32'd0);
    tick();
    chk("li_addi_inst", out_inst0, 32'hFFF50513);
    chk("li_addi_last", {31'd0, out_last0}, 32'd1);
    chk("li_addi_valid", {31'd0, out_valid0}, 32'd1);
    chk("li_after_ready", {31'd0, in_ready0}, 32'd1);
    tick();
    chk("li_drain", {31'd0, out_valid0}, 32'd0);

    // Compact LI forms
    drive(3'd3, 4'h0, 5'd1, 5'd0, 5'd0, 32'h000007FF, 1'b0);
    chk("cli_small_inst", out_inst0, 32'h7FF00093);
    chk("cli_small_last", {31'd0, out_last0}, 32'd1);
    chk("cli_small_ready", {31'd0, in_ready0}, 32'd1);
    drive(3'd3, 4'h0, 5'd1, 5'd0, 5'd0, 32'h00010000, 1'b0);
    chk("cli_lui_inst", out_inst0, 32'h000100B7);
    chk("cli_lui_last", {31'd0, out_last0}, 32'd1);
    tick();

    // Non-compact LI x1,0x7FF
    drive(3'd3, 4'h0, 5'd1, 5'd0, 5'd0, 32'h000007FF, 1'b1);
    chk("nli_lui_inst", out_inst1, 32'h000000B7);
    chk("nli_lui_last", {31'd0, out_last1}, 32'd0);
    tick();
    chk("nli_addi_inst", out_inst1, 32'h7FF08093);
    chk("nli_addi_last", {31'd0, out_last1}, 32'd1);
    tick();
    chk("nli_drain", {31'd0, out_valid1}, 32'd0);

    // Illegal R (op 4'hA) and kind 5
    drive(3'd0, 4'hA, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    chk("illr_valid", {31'd0, out_valid0}, 32'd0);
    chk("illr_err", {31'd0, err0}, 32'd1);
    tick();
    chk("illr_err_pulse", {31'd0, err0}, 32'd0);
    drive(3'd5, 4'h0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    chk("kind5_valid", {31'd0, out_valid0}, 32'd0);
    chk("kind5_err", {31'd0, err0}, 32'd1);
    tick();
    chk("kind5_err_pulse", {31'd0, err0}, 32'd0);

    // Back-to-back ADD xN,x1,x2 stream
    in_kind = 3'd0; in_alu_opcode = 4'h0; in_rs1 = 5'd1; in_rs2 = 5'd2; in_imm = 32'd0;
    in_valid0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_rd = 5'(i + 1);
      #1;
      chk("stream_ready", {31'd0, in_ready0}, 32'd1);
      tick();
      exp_w = 32'h00208033 | (32'(i + 1) << 7);
      chk("stream_valid", {31'd0, out_valid0}, 32'd1);
      chk("stream_inst", out_inst0, exp_w);
    end
    in_valid0 = 1'b0;
    tick();
    chk("stream_drain", {31'd0, out_valid0}, 32'd0);

    // Reset while an LI pair is pending
    out_ready = 1'b0;
    drive(3'd3, 4'h0, 5'd10, 5'd0, 5'd0, 32'h12345FFF, 1'b0);
    chk("rli_lui_inst", out_inst0, 32'h12346537);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rli_async_valid", {31'd0, out_valid0}, 32'd0);
    chk("rli_async_inst", out_inst0, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rli_no_stale", {31'd0, out_valid0}, 32'd0);
    end
    drive(3'd0, 4'h8, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    chk("rli_next_inst", out_inst0, 32'h402081B3);
    chk("rli_next_last", {31'd0, out_last0}, 32'd1);
    tick();
    chk("rli_next_drain", {31'd0, out_valid0}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
